// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Upstream stage of the SRAM memory controller. Arbitrates between the CPU
//   instruction-fetch port and the data load/store port (data has fixed
//   priority), issues one access at a time on the controller's
//   go_n/ce_n/oe_n/we_n request interface, holds it for ACCESS_CYCLES cycles,
//   captures read data and returns a one-cycle ack to the winner. Also flags
//   accesses that fall in the 8-byte UART window.
//
//   Optional feature macro: MEM_ARB_STOP_CHECK_EN
//     defined   : the access count advances only while mem_stop_n is low; 16
//                 consecutive ACCESS cycles with mem_stop_n high end the access
//                 with read data 32'hDEADBEEF.
//     undefined : mem_stop_n is ignored and the fixed count is used.
//
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   i_req/i_addr        fetch request (held until i_ack), byte address
//   i_ack/i_rdata       one-cycle ack, fetched word valid with ack
//   d_req/d_we/d_wb     data request (held until d_ack), store, byte access
//   d_addr/d_wdata      data byte address, store data (bytes in [7:0])
//   d_ack/d_rdata       one-cycle ack, load data valid with ack
//   mem_addr/mem_din    address and write data to the controller
//   mem_dout            read data from the controller
//   mem_ce_n/oe_n/we_n  controller strobes, active-low
//   mem_wb, mem_uart    byte access flag, UART window hit
//   mem_go_n            low while the controller performs the access
//   mem_stop_n          controller status (used only with the macro)
module mem_bus_arbiter #(
  parameter int unsigned ACCESS_CYCLES = 3,
  parameter logic [21:0] UART_BASE     = 22'h3FFFF8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [21:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic        d_wb,
  input  logic [21:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic [21:0] mem_addr,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout,
  output logic        mem_ce_n,
  output logic        mem_oe_n,
  output logic        mem_we_n,
  output logic        mem_wb,
  output logic        mem_uart,
  output logic        mem_go_n,
  input  logic        mem_stop_n
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  localparam logic [3:0] CNT_INIT = 4'(ACCESS_CYCLES - 1);

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic        win_d;      // 1 = current access belongs to the data port
  logic        win_write;  // current access is a store

  logic [21:0] sel_addr;
  logic        advance;    // count may step this cycle
  logic        timeout;    // controller never engaged
  logic        finish;
  logic [31:0] rd_val;

  // Bits intentionally not consumed: fetch addr[1:0] is forced to 00, and
  // mem_stop_n is only observed when the stop check is built in.
  logic unused_ok;
  assign unused_ok = &{1'b0, i_addr[1:0], mem_stop_n};

  // Data has fixed priority; a fetch address is word-aligned here.
  always_comb begin
    sel_addr = d_req ? d_addr : {i_addr[21:2], 2'b00};
  end

`ifdef MEM_ARB_STOP_CHECK_EN
  logic [3:0] stall;

  always_comb begin
    advance = ~mem_stop_n;
    timeout = mem_stop_n && (stall == 4'd15);
    rd_val  = timeout ? 32'hDEADBEEF : mem_dout;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall <= '0;
    end else if (state != ACCESS) begin
      stall <= '0;
    end else if (mem_stop_n) begin
      stall <= stall + 4'd1;
    end else begin
      stall <= '0;
    end
  end
`else
  always_comb begin
    advance = 1'b1;
    timeout = 1'b0;
    rd_val  = mem_dout;
  end
`endif

  assign finish = (advance && (cnt == '0)) || timeout;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      win_d     <= 1'b0;
      win_write <= 1'b0;
      mem_go_n  <= 1'b1;
      mem_ce_n  <= 1'b1;
      mem_oe_n  <= 1'b1;
      mem_we_n  <= 1'b1;
      mem_addr  <= '0;
      mem_din   <= '0;
      mem_wb    <= 1'b0;
      mem_uart  <= 1'b0;
      i_ack     <= 1'b0;
      d_ack     <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (d_req || i_req) begin
            win_d     <= d_req;
            win_write <= d_req && d_we;
            mem_addr  <= sel_addr;
            mem_din   <= d_req ? d_wdata : '0;
            mem_wb    <= d_req && d_wb;
            mem_oe_n  <= d_req && d_we;
            mem_we_n  <= ~(d_req && d_we);
            mem_ce_n  <= 1'b0;
            mem_go_n  <= 1'b0;
            mem_uart  <= (sel_addr[21:3] == UART_BASE[21:3]);
            cnt       <= CNT_INIT;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          if (finish) begin
            if (!win_d) begin
              i_rdata <= rd_val;
            end else if (!win_write) begin
              d_rdata <= rd_val;
            end
            mem_go_n <= 1'b1;
            mem_ce_n <= 1'b1;
            mem_oe_n <= 1'b1;
            mem_we_n <= 1'b1;
            state    <= DONE;
          end else if (advance) begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          if (win_d) begin
            d_ack <= 1'b1;
          end else begin
            i_ack <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Testbench for mem_bus_arbiter: directed test-plan steps followed by
// randomized fetch/load/store transactions, checked against a
// transaction-level reference model.
module tb_mem_bus_arbiter;

  localparam int unsigned AC = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [21:0] i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic        d_wb;
  logic [21:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic [21:0] mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;
  logic        mem_ce_n;
  logic        mem_oe_n;
  logic        mem_we_n;
  logic        mem_wb;
  logic        mem_uart;
  logic        mem_go_n;
  logic        mem_stop_n;

  int checks   = 0;
  int failures = 0;

  // Reference model state: last word delivered to each requester.
  logic [31:0] exp_i_rdata = '0;
  logic [31:0] exp_d_rdata = '0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(
    .ACCESS_CYCLES(AC),
    .UART_BASE    (22'h3FFFF8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_ack     (i_ack),
    .i_rdata   (i_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_wb      (d_wb),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_ack     (d_ack),
    .d_rdata   (d_rdata),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_dout  (mem_dout),
    .mem_ce_n  (mem_ce_n),
    .mem_oe_n  (mem_oe_n),
    .mem_we_n  (mem_we_n),
    .mem_wb    (mem_wb),
    .mem_uart  (mem_uart),
    .mem_go_n  (mem_go_n),
    .mem_stop_n(mem_stop_n)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Runs one access whose request is already on the inputs (driven at a
  // negedge, so the next posedge is the IDLE issue edge, cycle 0). Expected
  // bus fields come from the access rules; go_n is low for 'lat' cycles and
  // the winner's ack appears at cycle lat+1. rv is the word the winner reads.
  task automatic txn(input bit is_d, input int unsigned lat, input logic [31:0] rv);
    logic [21:0] ea;
    logic        e_oe, e_we, e_wb, e_uart;
    ea     = is_d ? d_addr : {i_addr[21:2], 2'b00};
    e_oe   = is_d ? d_we : 1'b0;
    e_we   = is_d ? ~d_we : 1'b1;
    e_wb   = is_d ? d_wb : 1'b0;
    e_uart = ((ea >> 3) == (22'h3FFFF8 >> 3));
    if (!is_d) exp_i_rdata = rv;
    else if (!d_we) exp_d_rdata = rv;
    for (int unsigned c = 0; c <= lat + 1; c++) begin
      @(negedge clk);
      if (c == 0) begin
        chk("mem_addr", 32'(mem_addr), 32'(ea));
        chk("mem_oe_n", 32'(mem_oe_n), 32'(e_oe));
        chk("mem_we_n", 32'(mem_we_n), 32'(e_we));
        chk("mem_wb", 32'(mem_wb), 32'(e_wb));
        chk("mem_uart", 32'(mem_uart), 32'(e_uart));
        if (is_d) chk("mem_din", mem_din, d_wdata);
      end
      chk("mem_go_n", 32'(mem_go_n), 32'(c >= lat));
      chk("mem_ce_n", 32'(mem_ce_n), 32'(c >= lat));
      chk("i_ack", 32'(i_ack), 32'(!is_d && (c == lat + 1)));
      chk("d_ack", 32'(d_ack), 32'(is_d && (c == lat + 1)));
    end
    chk("i_rdata", i_rdata, exp_i_rdata);
    chk("d_rdata", d_rdata, exp_d_rdata);
    if (is_d) d_req = 1'b0;
    else i_req = 1'b0;
  endtask

  task automatic set_fetch(input logic [21:0] a);
    i_req  = 1'b1;
    i_addr = a;
  endtask

  task automatic set_data(input bit we, input bit wb, input logic [21:0] a, input logic [31:0] wd);
    d_req   = 1'b1;
    d_we    = we;
    d_wb    = wb;
    d_addr  = a;
    d_wdata = wd;
  endtask

  initial begin
    logic [31:0] rv;
    int unsigned kind;
    rst        = 1'b0;
    i_req      = 1'b0;
    i_addr     = '0;
    d_req      = 1'b0;
    d_we       = 1'b0;
    d_wb       = 1'b0;
    d_addr     = '0;
    d_wdata    = '0;
    mem_dout   = '0;
    mem_stop_n = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_go_n", 32'(mem_go_n), 32'd1);
    chk("rst_ce_n", 32'(mem_ce_n), 32'd1);
    chk("rst_oe_n", 32'(mem_oe_n), 32'd1);
    chk("rst_we_n", 32'(mem_we_n), 32'd1);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_din", mem_din, 32'd0);
    chk("rst_acks", 32'({i_ack, d_ack, mem_wb, mem_uart}), 32'd0);
    chk("rst_rdata", i_rdata | d_rdata, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Step 1: fetch, addr low bits forced to 00
    mem_dout = 32'h3C011234;
    set_fetch(22'h000105);
    txn(1'b0, AC, 32'h3C011234);

    // Step 2: byte store
    @(negedge clk);
    set_data(1'b1, 1'b1, 22'h000202, 32'h000000A5);
    txn(1'b1, AC, 32'h0);

    // Step 3: simultaneous requests, data first, fetch back-to-back
    @(negedge clk);
    mem_dout = 32'h11112222;
    set_fetch(22'h000040);
    set_data(1'b0, 1'b0, 22'h000080, 32'h0);
    txn(1'b1, AC, 32'h11112222);
    mem_dout = 32'h33334444;
    txn(1'b0, AC, 32'h33334444);

    // Step 4: UART window boundaries
    @(negedge clk);
    mem_dout = 32'h00000055;
    set_data(1'b0, 1'b1, 22'h3FFFF8, 32'h0);
    txn(1'b1, AC, 32'h00000055);
    mem_dout = 32'h00000066;
    set_data(1'b0, 1'b1, 22'h3FFFF0, 32'h0);
    txn(1'b1, AC, 32'h00000066);

    // Step 5: reset during ACCESS cycle 2 aborts with no later ack
    @(negedge clk);
    mem_dout = 32'hCAFEF00D;
    set_data(1'b0, 1'b0, 22'h000300, 32'h0);
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("abort_go_n", 32'(mem_go_n), 32'd1);
    chk("abort_ce_n", 32'(mem_ce_n), 32'd1);
    chk("abort_oe_we", 32'({mem_oe_n, mem_we_n}), 32'd3);
    d_req = 1'b0;
    exp_i_rdata = '0;
    exp_d_rdata = '0;
    @(negedge clk);
    rst = 1'b1;
    for (int unsigned c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("post_rst_acks", 32'({i_ack, d_ack}), 32'd0);
      chk("post_rst_go_n", 32'(mem_go_n), 32'd1);
    end
    mem_dout = 32'h0BADC0DE;
    set_data(1'b0, 1'b0, 22'h000300, 32'h0);
    txn(1'b1, AC, 32'h0BADC0DE);

    // Step 6: controller never engages
    @(negedge clk);
    mem_stop_n = 1'b1;
    mem_dout   = 32'h12345678;
    set_fetch(22'h000010);
`ifdef MEM_ARB_STOP_CHECK_EN
    txn(1'b0, 16, 32'hDEADBEEF);
`else
    txn(1'b0, AC, 32'h12345678);
`endif
    mem_stop_n = 1'b0;

    // Randomized transactions, sometimes with both requests raised together
    for (int unsigned n = 0; n < 40; n++) begin
      if ($urandom_range(0, 2) == 0) @(negedge clk);
      rv   = $urandom;
      kind = $urandom_range(0, 3);
      mem_dout = rv;
      if (kind == 0) begin
        set_fetch(22'($urandom));
        txn(1'b0, AC, rv);
      end else begin
        set_data(1'($urandom), 1'($urandom),
                 ($urandom_range(0, 3) == 0) ? {19'h7FFFF, 3'($urandom)} : 22'($urandom),
                 $urandom);
        if (kind == 3) set_fetch(22'($urandom));
        txn(1'b1, AC, rv);
        if (kind == 3) begin
          rv = $urandom;
          mem_dout = rv;
          txn(1'b0, AC, rv);
        end
      end
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
